// File: rtl/sweep_acq_ctrl_multi_if.sv
// sweep_acq_ctrl_multi_if: ACQ FIFO read side and USB data-path output
// of the multi-DAC sweep controller, bundled as one port.
interface sweep_acq_ctrl_multi_if;
  logic        ParallelData_en;
  logic [15:0] SweepACQFifoData;
  logic        SweepACQFifoData_rden;
  logic [15:0] SweepACQData;
  logic        SweepACQData_en;

  // Controller side
  modport master (
    input  ParallelData_en,
    input  SweepACQFifoData,
    output SweepACQFifoData_rden,
    output SweepACQData,
    output SweepACQData_en
  );

  // FIFO / data-path side
  modport slave (
    output ParallelData_en,
    output SweepACQFifoData,
    input  SweepACQFifoData_rden,
    input  SweepACQData,
    input  SweepACQData_en
  );
endinterface

// File: rtl/sweep_acq_ctrl_multi.sv
// sweep_acq_ctrl_multi: sweeps one of NUM_DAC Microroc threshold DACs from
// StartDAC to EndDAC (up or down, programmable step), collects
// MaxPackageNumber events per point from the ACQ FIFO and streams
// header / parameter / data / tail words to the USB data path.
// Optional macro SWEEP_EVENT_TIMEOUT_EN adds a 24-bit per-event timeout
// in WAIT_EVENT (emits 16'hFFEE and counts the event as taken).
module sweep_acq_ctrl_multi #(
  parameter int DAC_WIDTH       = 10,
  parameter int NUM_DAC         = 3,
  parameter int WORDS_PER_EVENT = 10,
  parameter int LOAD_DELAY      = 40000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         Clk,
  input  logic                         reset_n,
  input  logic                         SweepStart,
  input  logic                         SweepAbort,
  input  logic [1:0]                   DacSelect,
  input  logic [DAC_WIDTH-1:0]         StartDAC,
  input  logic [DAC_WIDTH-1:0]         EndDAC,
  input  logic [DAC_WIDTH-1:0]         DACStep,
  input  logic [CNT_WIDTH-1:0]         MaxPackageNumber,
  output logic                         SingleACQStart,
  output logic                         OneDACDone,
  output logic                         ACQDone,
  input  logic                         DataTransmitDone,
  output logic [NUM_DAC*DAC_WIDTH-1:0] OutDAC,
  output logic                         LoadSCParameter,
  input  logic                         MicrorocConfigDone,
  sweep_acq_ctrl_multi_if.master       acqBus
);

  localparam int DLY_W = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
  localparam logic [DLY_W-1:0]     DLY_LAST  = DLY_W'(LOAD_DELAY - 1);
  localparam logic [3:0]           WORD_LAST = 4'(WORDS_PER_EVENT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DAC_WIDTH-1:0] DAC_ONE   = DAC_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, HEADER, PARAM, LOAD, WAIT_LOAD, START_ACQ, WAIT_EVENT,
    READ, LATCH, OUT, CHECK_PKT, NEXT_DAC, TAIL, ABORT, DONE
  } state_t;

  state_t               stateReg;
  logic [1:0]           selReg;
  logic [DAC_WIDTH-1:0] codeReg, endReg, stepReg;
  logic                 downReg;
  logic [CNT_WIDTH-1:0] maxReg, pktCntReg;
  logic [3:0]           wordIdxReg;
  logic [15:0]          latchReg;
  logic                 cfgSeenReg;
  logic [DLY_W-1:0]     delayCntReg;
  logic [3:0]           eventCountReg, pdCntReg;
`ifdef SWEEP_EVENT_TIMEOUT_EN
  logic [23:0]          timeoutReg;
`endif

  // Bit-reversed code and the one-hot-slice OutDAC image for the current point
  logic [DAC_WIDTH-1:0]         revCode;
  logic [NUM_DAC*DAC_WIDTH-1:0] outDacNext;
  genvar gi;
  generate
    for (gi = 0; gi < DAC_WIDTH; gi++) begin : gRev
      assign revCode[gi] = codeReg[DAC_WIDTH-1-gi];
    end
    for (gi = 0; gi < NUM_DAC; gi++) begin : gSlice
      assign outDacNext[gi*DAC_WIDTH +: DAC_WIDTH] = (32'(selReg) == gi) ? revCode : '0;
    end
  endgenerate

  // Next code is formed one bit wider so underflow/overflow are visible, never wrapped
  logic [DAC_WIDTH:0] codeExt, stepExt, endExt, nextCode;
  logic               lastPoint, lastPkt, abortNow, consume, evtArrive, clearCnt;
  logic [15:0]        paramWord;
  assign codeExt   = {1'b0, codeReg};
  assign stepExt   = {1'b0, stepReg};
  assign endExt    = {1'b0, endReg};
  assign nextCode  = downReg ? (codeExt - stepExt) : (codeExt + stepExt);
  assign lastPoint = (codeReg == endReg) ||
                     (downReg ? (nextCode[DAC_WIDTH] || (nextCode < endExt)) : (nextCode > endExt));
  assign lastPkt   = !((pktCntReg + CNT_ONE) < maxReg);
  assign paramWord = {4'hD, selReg, 10'(codeReg)};
  assign abortNow  = SweepAbort && (stateReg != IDLE) && (stateReg != TAIL) &&
                     (stateReg != DONE) && (stateReg != ABORT);
  assign consume   = (stateReg == WAIT_EVENT) && (eventCountReg != 4'd0) && !abortNow;
  assign evtArrive = acqBus.ParallelData_en && (pdCntReg == WORD_LAST);
  // Pending events are dropped whenever acquisition is switched off
  assign clearCnt  = (stateReg == IDLE) || (stateReg == ABORT) || abortNow ||
                     ((stateReg == CHECK_PKT) && lastPkt);

  // Word strobe divider and saturating pending-event counter
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pdCntReg      <= '0;
      eventCountReg <= '0;
    end else if (clearCnt) begin
      pdCntReg      <= '0;
      eventCountReg <= '0;
    end else begin
      if (acqBus.ParallelData_en)
        pdCntReg <= (pdCntReg == WORD_LAST) ? 4'd0 : pdCntReg + 4'd1;
      if (evtArrive && !consume && (eventCountReg != 4'hF))
        eventCountReg <= eventCountReg + 4'd1;
      else if (!evtArrive && consume)
        eventCountReg <= eventCountReg - 4'd1;
    end
  end

  // Sweep sequencer with registered outputs
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg                     <= IDLE;
      selReg                       <= '0;
      codeReg                      <= '0;
      endReg                       <= '0;
      stepReg                      <= '0;
      downReg                      <= 1'b0;
      maxReg                       <= '0;
      pktCntReg                    <= '0;
      wordIdxReg                   <= '0;
      latchReg                     <= '0;
      cfgSeenReg                   <= 1'b0;
      delayCntReg                  <= '0;
      SingleACQStart               <= 1'b0;
      OneDACDone                   <= 1'b0;
      ACQDone                      <= 1'b0;
      OutDAC                       <= '0;
      LoadSCParameter              <= 1'b0;
      acqBus.SweepACQFifoData_rden <= 1'b0;
      acqBus.SweepACQData          <= '0;
      acqBus.SweepACQData_en       <= 1'b0;
`ifdef SWEEP_EVENT_TIMEOUT_EN
      timeoutReg                   <= '0;
`endif
    end else begin
      acqBus.SweepACQData_en       <= 1'b0;
      acqBus.SweepACQFifoData_rden <= 1'b0;
      OneDACDone                   <= 1'b0;
      LoadSCParameter              <= 1'b0;
      if (abortNow) begin
        // An in-flight FIFO word is simply never latched
        SingleACQStart <= 1'b0;
        stateReg       <= ABORT;
      end else begin
        case (stateReg)
          IDLE: if (SweepStart) begin
            selReg    <= DacSelect;
            codeReg   <= StartDAC;
            endReg    <= EndDAC;
            stepReg   <= (DACStep == '0) ? DAC_ONE : DACStep;
            maxReg    <= (MaxPackageNumber == '0) ? CNT_ONE : MaxPackageNumber;
            downReg   <= (StartDAC > EndDAC);
            stateReg  <= HEADER;
          end
          HEADER: begin
            acqBus.SweepACQData    <= 16'h5341;
            acqBus.SweepACQData_en <= 1'b1;
            stateReg               <= PARAM;
          end
          PARAM: begin
            acqBus.SweepACQData    <= paramWord;
            acqBus.SweepACQData_en <= 1'b1;
            OutDAC                 <= outDacNext;
            stateReg               <= LOAD;
          end
          LOAD: begin
            LoadSCParameter <= 1'b1;
            cfgSeenReg      <= 1'b0;
            delayCntReg     <= '0;
            stateReg        <= WAIT_LOAD;
          end
          WAIT_LOAD: begin
            if (!cfgSeenReg) begin
              if (MicrorocConfigDone) cfgSeenReg <= 1'b1;
            end else if (delayCntReg == DLY_LAST) begin
              stateReg <= START_ACQ;
            end else begin
              delayCntReg <= delayCntReg + DLY_W'(1);
            end
          end
          START_ACQ: begin
            SingleACQStart <= 1'b1;
            pktCntReg      <= '0;
            wordIdxReg     <= '0;
`ifdef SWEEP_EVENT_TIMEOUT_EN
            timeoutReg     <= '0;
`endif
            stateReg       <= WAIT_EVENT;
          end
          WAIT_EVENT: begin
            if (consume) begin
              acqBus.SweepACQFifoData_rden <= 1'b1;
              stateReg                     <= READ;
`ifdef SWEEP_EVENT_TIMEOUT_EN
              timeoutReg                   <= '0;
            end else if (evtArrive) begin
              timeoutReg <= '0;
            end else if (timeoutReg == 24'hFFFFFF) begin
              timeoutReg             <= '0;
              acqBus.SweepACQData    <= 16'hFFEE;
              acqBus.SweepACQData_en <= 1'b1;
              stateReg               <= CHECK_PKT;
            end else begin
              timeoutReg <= timeoutReg + 24'd1;
`endif
            end
          end
          READ:  stateReg <= LATCH;
          LATCH: begin
            latchReg <= acqBus.SweepACQFifoData;
            stateReg <= OUT;
          end
          OUT: begin
            acqBus.SweepACQData    <= latchReg;
            acqBus.SweepACQData_en <= 1'b1;
            if (wordIdxReg == WORD_LAST) begin
              wordIdxReg <= '0;
              stateReg   <= CHECK_PKT;
            end else begin
              wordIdxReg                   <= wordIdxReg + 4'd1;
              acqBus.SweepACQFifoData_rden <= 1'b1;
              stateReg                     <= READ;
            end
          end
          CHECK_PKT: begin
            if (!lastPkt) begin
              pktCntReg <= pktCntReg + CNT_ONE;
              stateReg  <= WAIT_EVENT;
            end else begin
              SingleACQStart <= 1'b0;
              OneDACDone     <= 1'b1;
              stateReg       <= NEXT_DAC;
            end
          end
          NEXT_DAC: begin
            if (lastPoint) begin
              stateReg <= TAIL;
            end else begin
              codeReg  <= nextCode[DAC_WIDTH-1:0];
              stateReg <= PARAM;
            end
          end
          TAIL: begin
            acqBus.SweepACQData    <= 16'hFF45;
            acqBus.SweepACQData_en <= 1'b1;
            ACQDone                <= 1'b1;
            stateReg               <= DONE;
          end
          ABORT: begin
            acqBus.SweepACQData    <= 16'hFFAB;
            acqBus.SweepACQData_en <= 1'b1;
            ACQDone                <= 1'b1;
            stateReg               <= DONE;
          end
          DONE: if (DataTransmitDone) begin
            ACQDone  <= 1'b0;
            stateReg <= IDLE;
          end
          default: stateReg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_acq_ctrl_multi.sv
// tb_sweep_acq_ctrl_multi: directed, table-driven bench for the multi-DAC
// sweep controller, with a counting FIFO model and an output-word monitor.
module tb_sweep_acq_ctrl_multi;
  localparam int WPE = 10;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SweepStart = 1'b0;
  logic        SweepAbort = 1'b0;
  logic        DataTransmitDone = 1'b0;
  logic [1:0]  DacSelect = '0;
  logic [9:0]  StartDAC = '0, EndDAC = '0, DACStep = '0;
  logic [15:0] MaxPackageNumber = '0;
  logic        MicrorocConfigDone;
  logic        SingleACQStart, OneDACDone, ACQDone, LoadSCParameter;
  logic [29:0] OutDAC;

  logic        autoStrobe = 1'b0, manualStrobe = 1'b0, cfgDone = 1'b1;
  logic [15:0] fifoWord = 16'h1000;

  sweep_acq_ctrl_multi_if acqBus();

  assign acqBus.ParallelData_en = (autoStrobe & SingleACQStart) | manualStrobe;
  assign MicrorocConfigDone     = cfgDone;

  sweep_acq_ctrl_multi #(
    .DAC_WIDTH(10), .NUM_DAC(3), .WORDS_PER_EVENT(WPE), .LOAD_DELAY(40), .CNT_WIDTH(16)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .SweepStart(SweepStart), .SweepAbort(SweepAbort),
    .DacSelect(DacSelect), .StartDAC(StartDAC), .EndDAC(EndDAC), .DACStep(DACStep),
    .MaxPackageNumber(MaxPackageNumber), .SingleACQStart(SingleACQStart),
    .OneDACDone(OneDACDone), .ACQDone(ACQDone), .DataTransmitDone(DataTransmitDone),
    .OutDAC(OutDAC), .LoadSCParameter(LoadSCParameter),
    .MicrorocConfigDone(MicrorocConfigDone), .acqBus(acqBus)
  );

  always #5 Clk = ~Clk;

  // FIFO model: incrementing words, valid one cycle after rden
  always @(posedge Clk) begin
    if (acqBus.SweepACQFifoData_rden) begin
      acqBus.SweepACQFifoData <= fifoWord;
      fifoWord <= fifoWord + 16'd1;
    end
  end

  // Output monitor
  logic [15:0] got[$];
  logic [15:0] expq[$];
  logic [29:0] dacAtParam[$];
  int doneCnt = 0, dataSeen = 0;
  always @(negedge Clk) begin
    if (acqBus.SweepACQData_en) begin
      got.push_back(acqBus.SweepACQData);
      if (acqBus.SweepACQData[15:12] == 4'hD) dacAtParam.push_back(OutDAC);
      if (acqBus.SweepACQData[15:12] == 4'h1) dataSeen++;
    end
    if (OneDACDone) doneCnt++;
  end

  int nChecks = 0, nPass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act === expv) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  typedef struct packed {
    logic [1:0]       sel;
    logic [9:0]       start;
    logic [9:0]       stop;
    logic [9:0]       step;
    logic [15:0]      maxPkt;
    logic [3:0]       effMax;
    logic [1:0]       nPts;
    logic [2:0][15:0] pw;
    logic [29:0]      dac0;
    logic [29:0]      dacLast;
  } vec_t;
  vec_t vecs[5];

  task automatic clearMon();
    got.delete(); dacAtParam.delete(); doneCnt = 0; dataSeen = 0;
  endtask

  task automatic buildExp(input vec_t v, input logic [15:0] base);
    logic [15:0] d;
    d = base;
    expq.delete();
    expq.push_back(16'h5341);
    for (int p = 0; p < int'(v.nPts); p++) begin
      expq.push_back(v.pw[p]);
      for (int k = 0; k < int'(v.effMax) * WPE; k++) begin
        expq.push_back(d);
        d = d + 16'd1;
      end
    end
    expq.push_back(16'hFF45);
  endtask

  task automatic compareStream(input string tag);
    int n;
    check($sformatf("%s_len", tag), 64'(got.size()), 64'(expq.size()));
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(expq[i]));
  endtask

  task automatic startSweep(input vec_t v);
    DacSelect = v.sel; StartDAC = v.start; EndDAC = v.stop;
    DACStep = v.step; MaxPackageNumber = v.maxPkt;
    SweepStart = 1'b1;
  endtask

  task automatic waitAcqDone(input string tag);
    int cyc = 0;
    while (!ACQDone && cyc < 5000) begin @(posedge Clk); #1; cyc++; end
    check($sformatf("%s_acqdone", tag), 64'(ACQDone), 64'd1);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic waitData(input string tag, input int n);
    int cyc = 0;
    while (dataSeen < n && cyc < 5000) begin @(posedge Clk); #1; cyc++; end
    check($sformatf("%s_datawait", tag), 64'(dataSeen >= n), 64'd1);
  endtask

  task automatic finishSweep(input string tag);
    SweepStart = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check($sformatf("%s_hold", tag), 64'(ACQDone), 64'd1);
    check($sformatf("%s_acqoff", tag), 64'(SingleACQStart), 64'd0);
    DataTransmitDone = 1'b1;
    @(posedge Clk); #1;
    DataTransmitDone = 1'b0;
    @(posedge Clk); #1;
    check($sformatf("%s_idle", tag), 64'(ACQDone), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    logic [63:0] d0;
    vecs[0] = '{sel:2'd0, start:10'd100, stop:10'd102, step:10'd1, maxPkt:16'd2, effMax:4'd2,
                nPts:2'd3, pw:{16'hD066, 16'hD065, 16'hD064}, dac0:30'h098, dacLast:30'h198};
    vecs[1] = '{sel:2'd2, start:10'd10, stop:10'd3, step:10'd3, maxPkt:16'd1, effMax:4'd1,
                nPts:2'd3, pw:{16'hD804, 16'hD807, 16'hD80A}, dac0:30'h14000000, dacLast:30'h08000000};
    vecs[2] = '{sel:2'd1, start:10'd1020, stop:10'd1023, step:10'd2, maxPkt:16'd1, effMax:4'd1,
                nPts:2'd2, pw:{16'h0000, 16'hD7FE, 16'hD7FC}, dac0:30'h0003FC00, dacLast:30'h0007FC00};
    vecs[3] = '{sel:2'd0, start:10'd7, stop:10'd8, step:10'd0, maxPkt:16'd0, effMax:4'd1,
                nPts:2'd2, pw:{16'h0000, 16'hD008, 16'hD007}, dac0:30'h380, dacLast:30'h040};
    vecs[4] = '{sel:2'd0, start:10'd5, stop:10'd5, step:10'd1, maxPkt:16'd3, effMax:4'd3,
                nPts:2'd1, pw:{16'h0000, 16'h0000, 16'hD005}, dac0:30'h280, dacLast:30'h280};

    repeat (3) @(posedge Clk);
    #1;
    check("reset_outs", 64'({SingleACQStart, OneDACDone, ACQDone, LoadSCParameter,
          acqBus.SweepACQFifoData_rden, acqBus.SweepACQData_en, OutDAC, acqBus.SweepACQData}), 64'd0);
    reset_n = 1'b1;
    autoStrobe = 1'b1;

    // Table-driven sweeps
    for (int i = 0; i < 4; i++) begin
      clearMon();
      base = fifoWord;
      buildExp(vecs[i], base);
      startSweep(vecs[i]);
      waitAcqDone($sformatf("v%0d", i));
      compareStream($sformatf("v%0d", i));
      d0 = (dacAtParam.size() > 0) ? 64'(dacAtParam[0]) : '1;
      check($sformatf("v%0d_dac0", i), d0, 64'(vecs[i].dac0));
      check($sformatf("v%0d_daclast", i), 64'(OutDAC), 64'(vecs[i].dacLast));
      check($sformatf("v%0d_donecnt", i), 64'(doneCnt), 64'(vecs[i].nPts));
      $display("sweep v%0d: start=%0d end=%0d step=%0d words=%0d points=%0d",
               i, vecs[i].start, vecs[i].stop, vecs[i].step, got.size(), doneCnt);
      finishSweep($sformatf("v%0d", i));
    end

    // Burst of 30 strobes during WAIT_LOAD buffers 3 events
    autoStrobe = 1'b0;
    cfgDone = 1'b0;
    clearMon();
    base = fifoWord;
    buildExp(vecs[4], base);
    startSweep(vecs[4]);
    begin
      int cyc = 0;
      while (!LoadSCParameter && cyc < 200) begin @(posedge Clk); #1; cyc++; end
      check("burst_loadpulse", 64'(LoadSCParameter), 64'd1);
    end
    for (int k = 0; k < 30; k++) begin
      manualStrobe = 1'b1;
      @(posedge Clk); #1;
    end
    manualStrobe = 1'b0;
    check("burst_evcnt", 64'(dut.eventCountReg), 64'd3);
    cfgDone = 1'b1;
    waitAcqDone("burst");
    compareStream("burst");
    $display("sweep burst: words=%0d points=%0d", got.size(), doneCnt);
    finishSweep("burst");

    // Abort in the middle of a point's data
    autoStrobe = 1'b1;
    clearMon();
    base = fifoWord;
    startSweep(vecs[0]);
    waitData("abort", 5);
    SweepAbort = 1'b1;
    @(posedge Clk); #1;
    SweepAbort = 1'b0;
    waitAcqDone("abort");
    expq.delete();
    expq.push_back(16'h5341);
    expq.push_back(16'hD064);
    for (int k = 0; k < 5; k++) expq.push_back(base + 16'(k));
    expq.push_back(16'hFFAB);
    compareStream("abort");
    $display("sweep abort: words=%0d", got.size());
    finishSweep("abort");
    check("abort_quiet", 64'(got.size()), 64'd8);

    // Asynchronous reset while in OUT, then restart with SweepStart held
    clearMon();
    startSweep(vecs[0]);
    waitData("rst", 3);
    @(posedge Clk); #1;
    reset_n = 1'b0;
    #1;
    check("rst_outs", 64'({SingleACQStart, OneDACDone, ACQDone, LoadSCParameter,
          acqBus.SweepACQFifoData_rden, acqBus.SweepACQData_en, OutDAC, acqBus.SweepACQData}), 64'd0);
    check("rst_evcnt", 64'(dut.eventCountReg), 64'd0);
    @(posedge Clk); #1;
    clearMon();
    base = fifoWord;
    buildExp(vecs[0], base);
    reset_n = 1'b1;
    waitAcqDone("restart");
    compareStream("restart");
    $display("sweep restart: words=%0d points=%0d", got.size(), doneCnt);
    finishSweep("restart");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
